// File: rtl/key_debounce_multi.sv
// Multi-channel key front end: 2-flop sync, per-key debounce FSM, press/release/long/repeat pulses.
// Latency: DEBOUNCE_CYC + 2 cycles from a clean raw edge to Key_Press/Key_Release and Key_State.
// Backpressure: none; the event outputs are free-running single-cycle pulses.
module key_debounce_multi #(
    parameter int N_KEYS       = 5,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LONG_CYC     = 100000000,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_CYC   = 10000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_KEYS-1:0] Key_In,
    output logic [N_KEYS-1:0] Key_State,
    output logic [N_KEYS-1:0] Key_Press,
    output logic [N_KEYS-1:0] Key_Release,
    output logic [N_KEYS-1:0] Key_Long,
    output logic [N_KEYS-1:0] Key_Repeat
);

    localparam logic AL   = (ACTIVE_LOW != 0);
    localparam int   DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int   HMAX = ((REPEAT_EN != 0) && (REPEAT_CYC > LONG_CYC)) ? REPEAT_CYC : LONG_CYC;
    localparam int   HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYC - 1);

    typedef enum logic {IDLE, HELD} state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic          sync1;
        logic          sync2;
        logic          p;
        state_t        state;
        logic [DW-1:0] dcnt;
        logic [HW-1:0] hcnt;
        logic          long_done;
        logic          press_q;
        logic          release_q;
        logic          long_q;
        logic          repeat_q;

        assign p = sync2 ^ AL;

        always_ff @(posedge CLK) begin
            if (RST) begin
                sync1     <= AL;
                sync2     <= AL;
                state     <= IDLE;
                dcnt      <= '0;
                hcnt      <= '0;
                long_done <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                sync1     <= Key_In[i];
                sync2     <= sync1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                repeat_q  <= 1'b0;
                case (state)
                    IDLE: begin
                        if (!p) begin
                            dcnt <= '0;
                        end else if (dcnt == DEB_LAST) begin
                            state     <= HELD;
                            dcnt      <= '0;
                            hcnt      <= '0;
                            long_done <= 1'b0;
                            press_q   <= 1'b1;
                        end else begin
                            dcnt <= dcnt + 1'b1;
                        end
                    end
                    HELD: begin
                        // An accepted release pre-empts any long/repeat due this cycle.
                        if (!p && (dcnt == DEB_LAST)) begin
                            state     <= IDLE;
                            dcnt      <= '0;
                            hcnt      <= '0;
                            long_done <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            dcnt <= p ? '0 : dcnt + 1'b1;
                            if (!long_done) begin
                                if (hcnt == LONG_LAST) begin
                                    long_q    <= 1'b1;
                                    long_done <= 1'b1;
                                    hcnt      <= '0;
                                end else begin
                                    hcnt <= hcnt + 1'b1;
                                end
                            end else if (REPEAT_EN != 0) begin
                                if (hcnt == REP_LAST) begin
                                    repeat_q <= 1'b1;
                                    hcnt     <= '0;
                                end else begin
                                    hcnt <= hcnt + 1'b1;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign Key_State[i]   = (state == HELD);
        assign Key_Press[i]   = press_q;
        assign Key_Release[i] = release_q;
        assign Key_Long[i]    = long_q;
        assign Key_Repeat[i]  = repeat_q;
    end

endmodule
